// File: rtl/updown_counter_n_pkg.sv
// Shared constants for the parametrised up/down counter: mode codes and
// one-shot FSM state encoding.
package updown_counter_pkg;

   localparam logic [1:0] MODE_WRAP    = 2'b00;
   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

endpackage

// File: rtl/updown_counter_n_if.sv
// Control and status bundle of the up/down counter. The master drives the
// controls; the slave (the counter) returns count and flags.
interface updown_counter_n_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             up_down;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [1:0]       mode;
   logic             clr_flags;
   logic [WIDTH-1:0] count;
   logic             at_max;
   logic             at_min;
   logic             wrap;
   logic             ovf;
   logic             unf;
   logic             done;

   modport master (
      output en, up_down, load, load_val, mode, clr_flags,
      input  count, at_max, at_min, wrap, ovf, unf, done
   );

   modport slave (
      input  en, up_down, load, load_val, mode, clr_flags,
      output count, at_max, at_min, wrap, ovf, unf, done
   );
endinterface

// File: rtl/updown_counter_n.sv
// Up/down counter over 0..MAX_VAL with load, enable, wrap/saturate/one-shot
// modes, wrap pulse and sticky overflow/underflow flags.
import updown_counter_pkg::*;

module updown_counter_n #(
   parameter int WIDTH     = 8,
   parameter int MAX_VAL   = (1 << WIDTH) - 1,
   parameter int RESET_VAL = 0
) (
   input  logic               clk,
   input  logic               reset,
   updown_counter_n_if.slave  bus
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

   logic [WIDTH-1:0] count_reg, count_next;
   logic             wrap_reg, wrap_next;
   logic             ovf_reg, ovf_next;
   logic             unf_reg, unf_next;
   state_t           state_reg, state_next;

   logic [WIDTH-1:0] lim_val;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] load_clamped;
   logic             at_lim;
   logic             set_ovf;
   logic             set_unf;

   always_comb begin
      count_next   = count_reg;
      wrap_next    = 1'b0;
      state_next   = state_reg;
      set_ovf      = 1'b0;
      set_unf      = 1'b0;
      lim_val      = bus.up_down ? MAX_C : '0;
      at_lim       = (count_reg == lim_val);
      step_val     = bus.up_down ? (count_reg + ONE_C) : (count_reg - ONE_C);
      load_clamped = (bus.load_val > MAX_C) ? MAX_C : bus.load_val;

      if (bus.load) begin
         count_next = load_clamped;
         state_next = ST_RUN;
      end else if (state_reg == ST_RUN && bus.en) begin
         if (bus.mode == MODE_ONESHOT) begin
            // One-shot never steps past the limit; it parks in DONE on it.
            if (at_lim) begin
               state_next = ST_DONE;
            end else begin
               count_next = step_val;
               if (step_val == lim_val) begin
                  state_next = ST_DONE;
               end
            end
         end else if (at_lim) begin
            // Reserved mode 11 falls through to wrap behaviour here.
            if (bus.mode != MODE_SAT) begin
               count_next = bus.up_down ? '0 : MAX_C;
               wrap_next  = 1'b1;
            end
            set_ovf = bus.up_down;
            set_unf = ~bus.up_down;
         end else begin
            count_next = step_val;
         end
      end

      ovf_next = (ovf_reg & ~bus.clr_flags) | set_ovf;
      unf_next = (unf_reg & ~bus.clr_flags) | set_unf;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= RST_C;
         wrap_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
         unf_reg   <= 1'b0;
         state_reg <= ST_RUN;
      end else begin
         count_reg <= count_next;
         wrap_reg  <= wrap_next;
         ovf_reg   <= ovf_next;
         unf_reg   <= unf_next;
         state_reg <= state_next;
      end
   end

   assign bus.count  = count_reg;
   assign bus.at_max = (count_reg == MAX_C);
   assign bus.at_min = (count_reg == '0);
   assign bus.wrap   = wrap_reg;
   assign bus.ovf    = ovf_reg;
   assign bus.unf    = unf_reg;
   assign bus.done   = (state_reg == ST_DONE);

endmodule

// File: tb/tb_updown_counter_n.sv
// Self-checking bench for updown_counter_n (WIDTH=4, MAX_VAL=9, RESET_VAL=0)
// against an integer-arithmetic reference model.
module tb_updown_counter_n;

   localparam int W  = 4;
   localparam int MX = 9;
   localparam int RV = 0;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   int m_cnt;
   bit m_wrap, m_ovf, m_unf, m_done;

   updown_counter_n_if #(.WIDTH(W)) bus ();

   updown_counter_n #(.WIDTH(W), .MAX_VAL(MX), .RESET_VAL(RV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] observed();
      return {bus.count, bus.wrap, bus.ovf, bus.unf, bus.done, bus.at_max, bus.at_min};
   endfunction

   function automatic logic [9:0] expected();
      return {4'(m_cnt), m_wrap, m_ovf, m_unf, m_done, m_cnt == MX, m_cnt == 0};
   endfunction

   // Reference behaviour evaluated on the inputs seen at the clock edge.
   task automatic model_update();
      bit so, su;
      int lim;
      so = 0;
      su = 0;
      if (reset) begin
         m_cnt = RV; m_wrap = 0; m_ovf = 0; m_unf = 0; m_done = 0;
         return;
      end
      m_wrap = 0;
      if (bus.load) begin
         m_cnt  = (int'(bus.load_val) > MX) ? MX : int'(bus.load_val);
         m_done = 0;
      end else if (!m_done && bus.en) begin
         lim = bus.up_down ? MX : 0;
         if (bus.mode == 2'b10) begin
            if (m_cnt != lim) m_cnt = m_cnt + (bus.up_down ? 1 : -1);
            if (m_cnt == lim) m_done = 1;
         end else if (m_cnt == lim) begin
            if (bus.mode != 2'b01) begin
               m_cnt  = bus.up_down ? 0 : MX;
               m_wrap = 1;
            end
            so = bus.up_down;
            su = !bus.up_down;
         end else begin
            m_cnt = m_cnt + (bus.up_down ? 1 : -1);
         end
      end
      m_ovf = (m_ovf && !bus.clr_flags) || so;
      m_unf = (m_unf && !bus.clr_flags) || su;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      reset = 0; bus.en = 0; bus.up_down = 0; bus.load = 0;
      bus.load_val = '0; bus.mode = 2'b00; bus.clr_flags = 0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      tick();
      tick();
      n_checks++;
      if (observed() !== 10'b0000_0000_01) begin
         n_fail++;
         $display("FAIL reset_state got=%b want=%b", observed(), 10'b0000_0000_01);
      end
      n_checks++;
      if (observed() !== expected()) begin
         n_fail++;
         $display("FAIL reset_model got=%b want=%b", observed(), expected());
      end
      $display("reset: count=%0d done=%b", bus.count, bus.done);
      idle();
   endtask

   task automatic test_wrap_up();
      logic [3:0] ec;
      idle();
      bus.en = 1; bus.up_down = 1; bus.mode = 2'b00;
      for (int i = 0; i < 12; i++) begin
         tick();
         ec = 4'((i + 1) % 10);
         n_checks++;
         if (bus.count !== ec || bus.wrap !== (ec == 4'd0) || observed() !== expected()) begin
            n_fail++;
            $display("FAIL wrap_up[%0d] got=%b want_count=%0d model=%b", i, observed(), ec, expected());
         end
         $display("wrap_up: count=%0d wrap=%b ovf=%b", bus.count, bus.wrap, bus.ovf);
      end
      n_checks++;
      if (bus.ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_up_ovf got=%b want=1", bus.ovf);
      end
      idle();
   endtask

   task automatic test_wrap_down();
      idle(); bus.clr_flags = 1; tick();
      idle(); bus.load = 1; bus.load_val = 4'd0; tick();
      idle(); bus.en = 1; bus.up_down = 0; tick();
      n_checks++;
      if (bus.count !== 4'd9 || bus.wrap !== 1'b1 || bus.unf !== 1'b1 || bus.ovf !== 1'b0
          || observed() !== expected()) begin
         n_fail++;
         $display("FAIL wrap_down got=%b model=%b", observed(), expected());
      end
      $display("wrap_down: count=%0d wrap=%b unf=%b", bus.count, bus.wrap, bus.unf);
      idle(); bus.load = 1; bus.load_val = 4'd0; tick();
      idle(); bus.en = 1; bus.up_down = 0; bus.clr_flags = 1; tick();
      n_checks++;
      if (bus.count !== 4'd9 || bus.unf !== 1'b1 || bus.wrap !== 1'b1 || observed() !== expected()) begin
         n_fail++;
         $display("FAIL set_wins got=%b model=%b", observed(), expected());
      end
      $display("set_wins: count=%0d unf=%b", bus.count, bus.unf);
      idle();
   endtask

   task automatic test_saturate();
      logic [3:0] ec;
      idle(); bus.clr_flags = 1; tick();
      idle(); bus.load = 1; bus.load_val = 4'd7; bus.mode = 2'b01; tick();
      idle(); bus.en = 1; bus.up_down = 1; bus.mode = 2'b01;
      for (int i = 0; i < 5; i++) begin
         tick();
         ec = (i < 2) ? 4'(8 + i) : 4'd9;
         n_checks++;
         if (bus.count !== ec || bus.wrap !== 1'b0 || observed() !== expected()) begin
            n_fail++;
            $display("FAIL saturate[%0d] got=%b want_count=%0d model=%b", i, observed(), ec, expected());
         end
         $display("saturate: count=%0d ovf=%b", bus.count, bus.ovf);
      end
      n_checks++;
      if (bus.at_max !== 1'b1 || bus.ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL saturate_flags at_max=%b ovf=%b want 1 1", bus.at_max, bus.ovf);
      end
      idle();
   endtask

   task automatic test_oneshot();
      idle(); bus.clr_flags = 1; tick();
      idle(); bus.load = 1; bus.load_val = 4'd5; tick();
      idle(); bus.en = 1; bus.up_down = 1; bus.mode = 2'b10;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (bus.count !== 4'(6 + i) || bus.done !== (i == 3) || observed() !== expected()) begin
            n_fail++;
            $display("FAIL oneshot_run[%0d] got=%b model=%b", i, observed(), expected());
         end
         $display("oneshot: count=%0d done=%b", bus.count, bus.done);
      end
      for (int i = 0; i < 4; i++) begin
         bus.mode    = 2'($urandom_range(0, 3));
         bus.up_down = 1'($urandom);
         tick();
         n_checks++;
         if (bus.count !== 4'd9 || bus.done !== 1'b1 || bus.ovf !== 1'b0 || bus.unf !== 1'b0
             || bus.wrap !== 1'b0 || observed() !== expected()) begin
            n_fail++;
            $display("FAIL oneshot_hold[%0d] got=%b model=%b", i, observed(), expected());
         end
         $display("oneshot_hold: mode=%0d count=%0d done=%b", bus.mode, bus.count, bus.done);
      end
      idle(); bus.load = 1; bus.load_val = 4'd2; tick();
      n_checks++;
      if (bus.count !== 4'd2 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL oneshot_exit count=%0d done=%b want 2 0", bus.count, bus.done);
      end
      $display("oneshot_exit: count=%0d done=%b", bus.count, bus.done);
      idle();
   endtask

   task automatic test_load();
      idle(); bus.load = 1; bus.load_val = 4'd14; tick();
      n_checks++;
      if (bus.count !== 4'd9 || observed() !== expected()) begin
         n_fail++;
         $display("FAIL load_clamp got=%0d want=9", bus.count);
      end
      $display("load_clamp: count=%0d", bus.count);
      idle(); bus.load = 1; bus.load_val = 4'd3; bus.en = 1; bus.up_down = 1; tick();
      n_checks++;
      if (bus.count !== 4'd3) begin
         n_fail++;
         $display("FAIL load_over_en got=%0d want=3", bus.count);
      end
      $display("load_over_en: count=%0d", bus.count);
      idle(); bus.load = 1; bus.load_val = 4'd0; tick();
      idle(); bus.en = 1; bus.up_down = 0; tick();
      idle(); bus.load = 1; bus.load_val = 4'd4; tick();
      idle(); bus.en = 1; bus.up_down = 1; tick();
      n_checks++;
      if (bus.count !== 4'd5 || bus.unf !== 1'b1 || observed() !== expected()) begin
         n_fail++;
         $display("FAIL pre_reset got=%b model=%b", observed(), expected());
      end
      reset = 1; bus.load = 1; bus.load_val = 4'd7; tick();
      n_checks++;
      if (observed() !== 10'b0000_0000_01) begin
         n_fail++;
         $display("FAIL reset_over_load got=%b want=%b", observed(), 10'b0000_0000_01);
      end
      $display("reset_over_load: count=%0d unf=%b done=%b", bus.count, bus.unf, bus.done);
      idle();
   endtask

   task automatic test_reversal();
      idle(); bus.clr_flags = 1; tick();
      idle(); bus.load = 1; bus.load_val = 4'd5; tick();
      idle(); bus.en = 1;
      for (int i = 0; i < 4; i++) begin
         bus.up_down = (i % 2 == 0);
         bus.mode    = 2'($urandom_range(0, 2));
         tick();
         n_checks++;
         if (bus.count !== ((i % 2 == 0) ? 4'd6 : 4'd5) || bus.ovf !== 1'b0 || bus.unf !== 1'b0
             || bus.wrap !== 1'b0 || observed() !== expected()) begin
            n_fail++;
            $display("FAIL reversal[%0d] got=%b model=%b", i, observed(), expected());
         end
         $display("reversal: dir=%b count=%0d", bus.up_down, bus.count);
      end
      idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset         = ($urandom_range(0, 39) == 0);
         bus.load      = ($urandom_range(0, 7) == 0);
         bus.en        = ($urandom_range(0, 3) != 0);
         bus.up_down   = 1'($urandom);
         bus.mode      = 2'($urandom_range(0, 3));
         bus.clr_flags = ($urandom_range(0, 9) == 0);
         bus.load_val  = 4'($urandom_range(0, 15));
         tick();
         n_checks++;
         if (observed() !== expected()) begin
            n_fail++;
            $display("FAIL random[%0d] got=%b model=%b", i, observed(), expected());
         end
         $display("random[%0d]: count=%0d w=%b o=%b u=%b d=%b", i, bus.count, bus.wrap,
                  bus.ovf, bus.unf, bus.done);
      end
      idle();
   endtask

   initial begin
      m_cnt = RV; m_wrap = 0; m_ovf = 0; m_unf = 0; m_done = 0;
      idle();
      test_reset();
      test_wrap_up();
      test_wrap_down();
      test_saturate();
      test_oneshot();
      test_load();
      test_reversal();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/updown_counter_n.md
# updown_counter_n

Parametrised up/down counter: next generation of the fixed 4-bit up/down counter, generalised to arbitrary width and modulus. Adds synchronous load, count enable, run-time mode select (wrap, saturate, one-shot), terminal-count flags, wrap pulse and sticky overflow/underflow flags. Used as a general event, timer or index counter in the Basic-Modules library. Single clock domain.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- MAX_VAL, 2**WIDTH-1, top count value; counting range is 0..MAX_VAL (must be ≤ 2**WIDTH-1)
- RESET_VAL, 0, value of count after reset (must be ≤ MAX_VAL)
- clk  in  1  clock; all activity on the rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  count enable; one step per cycle while high
- up_down  in  1  direction: 1 = up, 0 = down
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  load value; values > MAX_VAL are clamped to MAX_VAL
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap)
- clr_flags  in  1  clears ovf and unf
- count  out  WIDTH  current count (registered)
- at_max  out  1  count == MAX_VAL (combinational from count)
- at_min  out  1  count == 0 (combinational from count)
- wrap  out  1  registered 1-cycle pulse, high in the cycle count shows a wrapped value
- ovf  out  1  sticky: an up step was attempted at MAX_VAL
- unf  out  1  sticky: a down step was attempted at 0
- done  out  1  high while the one-shot FSM is in DONE

## Operation
- Priority per cycle: reset > load > en. en low with no load: count holds.
- reset: count=RESET_VAL, wrap=0, ovf=0, unf=0, state=RUN (done=0). Overrides load and en in the same cycle, including mid-count and in DONE.
- load: count=clamp(load_val), state=RUN, wrap=0. Flags unchanged except by clr_flags. load exits DONE.
- en step when not at a limit: count ±1 per up_down, in all modes.
- Step at a limit (up at MAX_VAL, or down at 0):
  - wrap mode: count → 0 (up) or MAX_VAL (down); wrap=1 for that cycle; ovf/unf set.
  - saturate mode: count holds; ovf/unf set; wrap=0.
  - one-shot mode: step never occurs in RUN (see FSM); with en high in DONE no flag is set.
- One-shot FSM, states RUN and DONE:
  - RUN → DONE when mode=10, en=1, and the step lands count on the limit in the current direction (MAX_VAL up, 0 down).
  - RUN → DONE also when mode=10, en=1, and count already sits on the limit in the current direction (no step, no flag).
  - DONE holds count and ignores en, up_down and mode changes; exits to RUN only on load or reset.
  - Outside mode 10 the FSM stays in RUN.
- Flags: clr_flags clears ovf/unf next cycle. Simultaneous set and clear → set wins.
- Direction reversal is legal on any cycle; takes effect on that cycle's step.
- mode may change on any cycle; it applies to that cycle's step.

## Timing
- All outputs are registered except at_max/at_min, which decode the registered count.
- Latency: en/load/reset sampled at edge N are visible on count at N+1.
- wrap is high for exactly one cycle, aligned with the wrapped count value.
- ovf/unf assert in the same cycle count reflects the offending step.
- done asserts in the same cycle count first shows the limit value.

## Structure
- Package updown_counter_pkg holds:
  - mode constants MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10;
  - FSM state encoding ST_RUN/ST_DONE.
- Single module, no sub-modules. Next-value and limit-detect logic is one combinational block feeding one register block.

## Test plan
Parameters for all scenarios: WIDTH=4, MAX_VAL=9, RESET_VAL=0.
- Reset then en=1, up_down=1, mode=00 for 12 cycles → count 1..9,0,1,2; wrap high only on the cycle showing 0; ovf=1.
- mode=00, down from 0 → count 9; wrap pulse; unf=1. Then clr_flags=1 together with another down step at 0 → unf stays 1 (set wins).
- mode=01, up from 7 for 5 cycles → 8,9,9,9,9; at_max=1; ovf=1; wrap never asserts.
- mode=10, load 5, up to 9 → done=1 when count shows 9. en continues plus a mode change → count stays 9, no flags. load 2 → done=0, count=2.
- load_val=14 → count=9 (clamped). load and en in the same cycle → load wins. reset asserted together with load=1 mid-count → count=0, done=0, flags cleared.
- Reverse up_down every cycle from 5 with en=1 → count alternates 6,5,6,5; no flags.
